fifo_read_ctrl: RTL and testbench
=================================

# fifo_read_ctrl

Read-side controller for the async FIFO, in the `rclk` domain, directly downstream of the dual-port FIFO memory. It synchronizes the write pointer, generates `raddr`/`rclken` for the memory's registered read port, and absorbs the memory's one-cycle read latency in a 2-entry output buffer. The consumer sees a valid/ready stream. It also returns a Gray-coded read pointer to the write domain.

## Interface
- `DATA_WIDTH`, default 8: word width; must match the memory.
- `ADDR_WIDTH`, default 8: memory address width. Pointers are `ADDR_WIDTH+1` bits.

Ports:
- `rclk` in 1: read clock. Only clock in the block.
- `rrst` in 1: reset; synchronous, active-high.
- `wptr_gray` in ADDR_WIDTH+1: write pointer, Gray-coded, from the `wclk` domain (asynchronous to `rclk`).
- `rptr_gray` out ADDR_WIDTH+1: read pointer, Gray-coded and registered, to the write domain.
- `raddr` out ADDR_WIDTH: memory read address.
- `rclken` out 1: memory read enable.
- `mem_rdata` in DATA_WIDTH: memory read data, valid the cycle after the `rclken` edge.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: consumer accepts the word.
- `m_data` out DATA_WIDTH: output word.
- `rempty` out 1: memory holds no unread words (from the read-side view).
- `rcount` out ADDR_WIDTH+1: words in memory not yet issued for read.

## Operation
- **Synchronizer:** 2-flop chain `wptr_gray -> wq1 -> wq2`. `wq2_bin = gray2bin(wq2)`.
- **Read pointer:** `rbin` is a binary counter of `ADDR_WIDTH+1` bits.
  - `raddr = rbin[ADDR_WIDTH-1:0]`.
  - `rptr_gray` is a register loaded with `bin2gray(rbin_next)`.
- **Empty and count** (combinational from registers):
  - `rempty = (rbin == wq2_bin)`, compared across all `ADDR_WIDTH+1` bits.
  - `rcount = wq2_bin - rbin`, modulo `2^(ADDR_WIDTH+1)`.
- **In-flight flag:** `inflight` is a register equal to `rclken` from the previous cycle.
- **Pop:** `pop = m_valid & m_ready`.
- **Issue:** `rclken = !rrst & !rempty & (buf_cnt + inflight - pop < 2)`. On `rclken`, `rbin` increments.
- **Output buffer:** 2-entry FIFO (`buf_cnt` 0..2).
  - When `inflight` is set, `mem_rdata` is written into the buffer.
  - `m_data` is the head entry. `m_valid = (buf_cnt != 0)`.
  - Capture and pop in the same cycle are both honoured.
  - The issue rule guarantees the buffer never overflows.
- **Stream rules:** while `m_valid & !m_ready`, both `m_valid` and `m_data` hold stable. Words leave in write order with no loss or duplication.
- **Wrap-around:** `rbin` wraps from `2^(ADDR_WIDTH+1)-1` to 0; `raddr` wraps every `2^ADDR_WIDTH` reads. Empty detection stays correct across wraps.
- **Reset** (synchronous, takes effect at the edge where `rrst` is high):
  - Cleared to 0: `rbin`, `wq1`, `wq2`, `rptr_gray`, `inflight`, `buf_cnt`, buffer head/tail, `m_data`.
  - Resulting outputs: `m_valid=0`, `rclken=0`, `raddr=0`, `rempty=1`, `rcount=0`.
  - Reset mid-operation discards any in-flight read and all buffered words; none are emitted after reset.
  - The write domain is reset concurrently (system requirement).

## Timing
- `wptr_gray` change before edge E0: `wq2` updates at E1, so `rempty` falls and `rclken` rises in the cycle after E1.
  - Memory reads at E2 and data is captured at E3.
  - `m_valid` is high after E3: 4 edges from the write-pointer change to output.
- From `rclken` high to the word visible on `m_data`: 2 edges (buffer empty, no back-pressure).
- `rptr_gray` updates at the same edge that `rbin` advances.
- **Sustained throughput:** with `m_ready=1` and the memory non-empty, one word per cycle, no bubbles after the first.
- **Back-pressure:** with `m_ready=0`, at most 2 reads are issued beyond the last accepted word.

## Test plan
1. **Reset:** hold `rrst` high for 2 cycles with `wptr_gray=0` -> `m_valid=0`, `rempty=1`, `rclken=0`, `raddr=0`, `rptr_gray=0`, `rcount=0`.
2. **Single word:** memory[0]=0xA5; `wptr_gray` 0->1; `m_ready=1` -> `rclken` high exactly 1 cycle with `raddr=0`; `m_valid` high after the 4th edge with `m_data=0xA5` for 1 cycle; `rptr_gray=1`; `rempty=1` afterwards.
3. **Back-pressure:** 5 words (0x10..0x14) written, `wptr_gray=gray(5)=7`, `m_ready=0` -> exactly 2 `rclken` pulses, `m_data` stable at 0x10, `rcount=3`. Then `m_ready=1` -> 0x10..0x14 emitted on consecutive cycles.
4. **Wrap-around:** `ADDR_WIDTH=3`; stream 20 words with values equal to their index, `m_ready=1` -> `raddr` goes 7->0 twice; `rptr_gray` follows `gray(k mod 16)`; outputs 0..19 in order.
5. **Reset mid-operation:** `buf_cnt=2`, `inflight=1`, assert `rrst` for 1 cycle -> next cycle `m_valid=0`, `raddr=0`, `rptr_gray=0`; no stale word appears after release with `wptr_gray=0`.
6. **Random ready:** `wptr_gray` advanced by 1 every 3rd cycle for 200 words, `m_ready` random 50% -> scoreboard matches, no `rclken` while `rempty=1`, no overflow (`buf_cnt<=2`).

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: async FIFO read side; syncs wptr_gray, drives raddr/rclken, buffers mem_rdata into an m_valid/m_ready stream, returns rptr_gray, rempty, rcount
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  rclken,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   rcount
);
  logic [ADDR_WIDTH:0] wq1, wq2, wq2_bin, rbin, rbin_next;
  logic inflight, pop, hd, tl;
  logic [1:0] buf_cnt;
  logic [2:0] occ;
  logic [DATA_WIDTH-1:0] buf_q [2];
  always_comb begin
    wq2_bin = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) wq2_bin[i] = ^(wq2 >> i);
  end
  assign rempty = rbin == wq2_bin;
  assign rcount = wq2_bin - rbin;
  assign raddr = rbin[ADDR_WIDTH-1:0];
  assign m_valid = buf_cnt != 2'd0;
  assign m_data = buf_q[hd];
  assign pop = m_valid & m_ready;
  assign occ = {1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, pop};
  assign rclken = !rrst && !rempty && occ < 3'd2;
  assign rbin_next = rbin + {{ADDR_WIDTH{1'b0}}, rclken};
  always_ff @(posedge rclk) begin
    if (rrst) begin
      wq1 <= '0;
      wq2 <= '0;
      rbin <= '0;
      rptr_gray <= '0;
      inflight <= 1'b0;
      buf_cnt <= 2'd0;
      hd <= 1'b0;
      tl <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      wq1 <= wptr_gray;
      wq2 <= wq1;
      rbin <= rbin_next;
      rptr_gray <= rbin_next ^ (rbin_next >> 1);
      inflight <= rclken;
      buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
      if (inflight) begin
        buf_q[tl] <= mem_rdata;
        tl <= ~tl;
      end
      if (pop) hd <= ~hd;
    end
  end
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: vector table, directed corner cases and random traffic against a behavioural stream model
module tb_fifo_read_ctrl;
  localparam int DW = 8;
  localparam int AW = 3;
  logic clk = 1'b0, rrst = 1'b1, m_ready = 1'b0;
  logic rclken, m_valid, rempty;
  logic [AW:0] wptr_gray = '0, rptr_gray, rcount;
  logic [AW-1:0] raddr;
  logic [DW-1:0] mem_rdata = '0, m_data;
  logic [DW-1:0] mem [8];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  fifo_read_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .rclk(clk), .rrst(rrst), .wptr_gray(wptr_gray), .rptr_gray(rptr_gray),
    .raddr(raddr), .rclken(rclken), .mem_rdata(mem_rdata), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .rempty(rempty), .rcount(rcount)
  );
  always @(posedge clk) if (rclken) mem_rdata <= mem[raddr];
  typedef struct {
    logic r; logic [AW:0] w; logic rdy;
    logic v; logic c; logic [AW-1:0] a; logic e; logic [DW-1:0] d; logic [AW:0] p; logic [AW:0] n;
  } vec_t;
  vec_t tv [8];
  logic [AW:0] wbin = '0, rptr_m = '0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] prev_data = '0;
  int rd_q [$];
  int cyc = 0, n_cap = 0, n_pop = 0, n_iss = 0, tp_first = 0, tp_last = 0, tp_n = 0;
  bit mon = 1'b0, prev_hold = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  function automatic logic [AW:0] g(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [AW:0] b_of(input logic [AW:0] x);
    logic [AW:0] r;
    r[AW] = x[AW];
    for (int i = AW - 1; i >= 0; i--) r[i] = r[i+1] ^ x[i];
    return r;
  endfunction
  function automatic bit full();
    logic [AW:0] d;
    d = wbin - b_of(rptr_gray);
    return d[AW];
  endfunction
  task automatic wr(input logic [DW-1:0] d);
    mem[wbin[AW-1:0]] = d;
    exp_q.push_back(d);
    wbin = wbin + 1'b1;
    wptr_gray = g(wbin);
  endtask
  task automatic clear_model();
    rd_q.delete();
    exp_q.delete();
    n_cap = 0; n_pop = 0; n_iss = 0; tp_n = 0;
    prev_hold = 1'b0;
    rptr_m = '0;
  endtask
  task automatic do_reset(input int n);
    mon = 1'b0;
    rrst = 1'b1;
    wbin = '0;
    wptr_gray = '0;
    repeat (n) @(posedge clk);
    #1 rrst = 1'b0;
    clear_model();
    mon = 1'b1;
  endtask
  task automatic drain(input int limit);
    for (int i = 0; i < limit && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(negedge clk);
    if (mon) begin
      while (rd_q.size() > 0 && rd_q[0] + 1 <= cyc) begin
        void'(rd_q.pop_front());
        n_cap++;
      end
      chk("m_valid_timing", int'(m_valid), int'(n_cap > n_pop));
      chk("rptr_gray", int'(rptr_gray), int'(g(rptr_m)));
      if (prev_hold) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_data", int'(m_data), int'(prev_data));
      end
      if (rclken) begin
        chk("issue_nonempty", int'(rempty), 0);
        chk("raddr_seq", int'(raddr), int'(rptr_m[AW-1:0]));
      end
      chk("outstanding_le2", int'(n_iss + int'(rclken) - n_pop - int'(m_valid && m_ready) <= 2), 1);
      if (m_valid && m_ready) begin
        chk("word_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("data_order", int'(m_data), int'(exp_q.pop_front()));
        n_pop++;
        if (tp_n == 0) tp_first = cyc;
        tp_last = cyc;
        tp_n++;
      end
      if (rclken) begin
        rd_q.push_back(cyc + 1);
        n_iss++;
        rptr_m = rptr_m + 1'b1;
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end
  initial begin
    int sc, sent;
    tv[0] = '{1, 0, 1, 0, 0, 0, 1, 8'h00, 0, 0};
    tv[1] = '{0, 0, 1, 0, 0, 0, 1, 8'h00, 0, 0};
    tv[2] = '{0, 1, 1, 0, 0, 0, 1, 8'h00, 0, 0};
    tv[3] = '{0, 1, 1, 0, 0, 0, 1, 8'h00, 0, 0};
    tv[4] = '{0, 1, 1, 0, 1, 0, 0, 8'h00, 0, 1};
    tv[5] = '{0, 1, 1, 0, 0, 1, 1, 8'h00, 1, 0};
    tv[6] = '{0, 1, 1, 1, 0, 1, 1, 8'hA5, 1, 0};
    tv[7] = '{0, 1, 1, 0, 0, 1, 1, 8'h00, 1, 0};
    mem[0] = 8'hA5;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rrst = tv[i].r;
      wptr_gray = tv[i].w;
      m_ready = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_m_valid", i), int'(m_valid), int'(tv[i].v));
      chk($sformatf("v%0d_rclken", i), int'(rclken), int'(tv[i].c));
      chk($sformatf("v%0d_raddr", i), int'(raddr), int'(tv[i].a));
      chk($sformatf("v%0d_rempty", i), int'(rempty), int'(tv[i].e));
      chk($sformatf("v%0d_rptr_gray", i), int'(rptr_gray), int'(tv[i].p));
      chk($sformatf("v%0d_rcount", i), int'(rcount), int'(tv[i].n));
      if (tv[i].v) chk($sformatf("v%0d_m_data", i), int'(m_data), int'(tv[i].d));
      @(posedge clk);
      #1;
    end
    do_reset(1);
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) wr(8'h10 + 8'(k));
    repeat (12) @(posedge clk);
    #1;
    chk("bp_issues", n_iss, 2);
    chk("bp_valid", int'(m_valid), 1);
    chk("bp_data", int'(m_data), 'h10);
    chk("bp_rcount", int'(rcount), 3);
    tp_n = 0;
    m_ready = 1'b1;
    drain(50);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_count", tp_n, 5);
    chk("bp_consecutive", tp_last - tp_first, 4);
    do_reset(1);
    m_ready = 1'b1;
    tp_n = 0;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 50 && full(); i++) begin
        @(posedge clk);
        #1;
      end
      wr(8'(k));
      @(posedge clk);
      #1;
    end
    drain(60);
    chk("wrap_drained", exp_q.size(), 0);
    chk("wrap_count", tp_n, 20);
    chk("wrap_consecutive", tp_last - tp_first, 19);
    chk("wrap_rptr_gray", int'(rptr_gray), int'(g(4'd4)));
    chk("wrap_raddr", int'(raddr), 4);
    do_reset(1);
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) wr(8'h30 + 8'(k));
    for (int i = 0; i < 20 && !m_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_valid_before", int'(m_valid), 1);
    do_reset(1);
    chk("mid_m_valid", int'(m_valid), 0);
    chk("mid_raddr", int'(raddr), 0);
    chk("mid_rptr_gray", int'(rptr_gray), 0);
    chk("mid_rempty", int'(rempty), 1);
    chk("mid_rcount", int'(rcount), 0);
    chk("mid_rclken", int'(rclken), 0);
    sc = 0;
    m_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (m_valid) sc++;
    end
    chk("mid_stale_words", sc, 0);
    @(posedge clk);
    #1;
    sent = 0;
    for (int i = 0; i < 3000 && sent < 200; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (i % 3 == 0 && !full()) begin
        wr(8'($urandom));
        sent++;
      end
      @(posedge clk);
      #1;
    end
    chk("rand_sent", sent, 200);
    m_ready = 1'b1;
    drain(100);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_pops", n_pop, 200);
    mon = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
